// File: rtl/riscv_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Imported by the loader top and its byte packer.
package riscv_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        LOAD,
        START,
        RUN,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_WIDTH      = 16;

endpackage

// File: rtl/ins_mem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Raises wordValid for one cycle after the fourth byte of each word.
module byte_packer
    import riscv_loader_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rstN_i,
    input  logic                          clear_i,
    input  logic                          en_i,
    input  logic [7:0]                    byte_i,
    output logic                          lastByte_o,
    output logic [BYTES_PER_WORD*8-1:0]   word_o,
    output logic                          wordValid_o
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0]            byteIdx_q;
    logic [BYTES_PER_WORD*8-1:0] acc_q;
    logic                        wordValid_q;

    assign lastByte_o  = (byteIdx_q == IDX_W'(BYTES_PER_WORD - 1));
    assign word_o      = acc_q;
    assign wordValid_o = wordValid_q;

    // The accumulator stays stable through the write cycle, so it doubles
    // as the write data register.
    always_ff @(posedge clk_i) begin
        if (!rstN_i) begin
            byteIdx_q   <= '0;
            acc_q       <= '0;
            wordValid_q <= 1'b0;
        end else begin
            wordValid_q <= 1'b0;
            if (clear_i) begin
                byteIdx_q <= '0;
            end else if (en_i) begin
                acc_q[{byteIdx_q, 3'b000} +: 8] <= byte_i;
                byteIdx_q   <= byteIdx_q + 1'b1;
                wordValid_q <= lastByte_o;
            end
        end
    end

endmodule

// File: rtl/ins_mem_loader.sv
// Boot loader: length header, byte stream into instruction memory,
// then start the processor and wait for it to finish.
module ins_mem_loader
    import riscv_loader_pkg::*;
#(
    parameter int IM_MEM_DEPTH      = 256,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         loadStart,
    input  logic [7:0]                   byteIn,
    input  logic                         byteValid,
    output logic                         byteReady,
    output logic                         imWriteEn,
    output logic [31:0]                  imAddress,
    output logic [INSTRUCTION_WIDTH-1:0] imWriteData,
    output logic                         startProcess,
    input  logic                         endProcess,
    output logic                         busy,
    output logic                         loadDone,
    output logic                         error
);

    localparam logic [LEN_WIDTH:0] DEPTH_L = (LEN_WIDTH + 1)'(IM_MEM_DEPTH);

    loader_state_t        state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] wordIdx_q;
    logic [31:0]          imAddress_q;
    logic                 byteReady_q;
    logic                 startProcess_q;
    logic                 busy_q;
    logic                 loadDone_q;
    logic                 error_q;

    logic                 xfer;
    logic                 loadXfer;
    logic                 lastByte;
    logic                 wordValid;
    logic [LEN_WIDTH-1:0] lenFull;
    logic [LEN_WIDTH-1:0] lenLast;

    assign xfer     = byteValid && byteReady_q;
    assign loadXfer = xfer && (state_q == LOAD);
    assign lenFull  = {byteIn, len_q[7:0]};
    assign lenLast  = len_q - 1'b1;

    byte_packer u_packer (
        .clk_i       (clk),
        .rstN_i      (rstN),
        .clear_i     (state_q != LOAD),
        .en_i        (loadXfer),
        .byte_i      (byteIn),
        .lastByte_o  (lastByte),
        .word_o      (imWriteData),
        .wordValid_o (wordValid)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (loadStart) state_d = LEN_LO;
            LEN_LO: if (xfer) state_d = LEN_HI;
            LEN_HI: begin
                if (xfer) begin
                    if (lenFull == '0 || {1'b0, lenFull} > DEPTH_L)
                        state_d = ERROR;
                    else
                        state_d = LOAD;
                end
            end
            LOAD: begin
                if (loadXfer && lastByte && wordIdx_q == lenLast)
                    state_d = START;
            end
            START:  state_d = RUN;
            RUN:    if (endProcess) state_d = DONE;
            DONE:   if (loadStart) state_d = LEN_LO;
            ERROR:  if (loadStart) state_d = LEN_LO;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs follow the next state so they are glitch-free regs.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q        <= IDLE;
            len_q          <= '0;
            wordIdx_q      <= '0;
            imAddress_q    <= '0;
            byteReady_q    <= 1'b0;
            startProcess_q <= 1'b0;
            busy_q         <= 1'b0;
            loadDone_q     <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            byteReady_q    <= state_d inside {LEN_LO, LEN_HI, LOAD};
            busy_q         <= !(state_d inside {IDLE, DONE, ERROR});
            loadDone_q     <= (state_d == DONE);
            error_q        <= (state_d == ERROR);
            startProcess_q <= (state_q == START);
            if (state_q == LEN_LO && xfer)
                len_q[7:0] <= byteIn;
            if (state_q == LEN_HI) begin
                wordIdx_q <= '0;
                if (xfer)
                    len_q[15:8] <= byteIn;
            end
            if (loadXfer && lastByte) begin
                imAddress_q <= {14'b0, wordIdx_q, 2'b00};
                wordIdx_q   <= wordIdx_q + 1'b1;
            end
        end
    end

    assign byteReady    = byteReady_q;
    assign imWriteEn    = wordValid;
    assign imAddress    = imAddress_q;
    assign startProcess = startProcess_q;
    assign busy         = busy_q;
    assign loadDone     = loadDone_q;
    assign error        = error_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader: normal, error, gap,
// full-depth and mid-load reset scenarios.
module tb_ins_mem_loader;

    logic        clk = 1'b0;
    logic        rstN;
    logic        loadStart;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        byteReady;
    logic        imWriteEn;
    logic [31:0] imAddress;
    logic [31:0] imWriteData;
    logic        startProcess;
    logic        endProcess;
    logic        busy;
    logic        loadDone;
    logic        error;

    int errors = 0;
    int checks = 0;
    int starts = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    always #5 clk = ~clk;

    ins_mem_loader #(.IM_MEM_DEPTH(256), .INSTRUCTION_WIDTH(32)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .loadStart    (loadStart),
        .byteIn       (byteIn),
        .byteValid    (byteValid),
        .byteReady    (byteReady),
        .imWriteEn    (imWriteEn),
        .imAddress    (imAddress),
        .imWriteData  (imWriteData),
        .startProcess (startProcess),
        .endProcess   (endProcess),
        .busy         (busy),
        .loadDone     (loadDone),
        .error        (error)
    );

    always @(negedge clk) begin
        if (imWriteEn) begin
            wa.push_back(imAddress);
            wd.push_back(imWriteData);
        end
        if (startProcess) starts++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        starts = 0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        byteIn    = b;
        byteValid = 1'b1;
        while (!byteReady && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!byteReady) begin
            errors++;
            $display("FAIL send_timeout byte=%02h byteReady=%b want 1", b, byteReady);
        end else begin
            tick();
        end
    endtask

    task automatic start_load();
        loadStart = 1'b1;
        tick();
        loadStart = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        endProcess = 1'b1;
        tick();
        endProcess = 1'b0;
        checks++;
        if ({loadDone, busy} !== 2'b10) begin
            errors++;
            $display("FAIL %s_done {loadDone,busy}=%b want 10", tag, {loadDone, busy});
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        tick();
        tick();
        checks++;
        if ({byteReady, imWriteEn, startProcess, busy, loadDone, error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {byteReady, imWriteEn, startProcess, busy, loadDone, error});
        end
        checks++;
        if (imAddress !== 32'h0 || imWriteData !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus addr=%h data=%h want 0/0", imAddress, imWriteData);
        end
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_normal_load(input string tag);
        clear_log();
        start_load();
        checks++;
        if ({byteReady, busy} !== 2'b11) begin
            errors++;
            $display("FAIL %s_lenlo {byteReady,busy}=%b want 11", tag, {byteReady, busy});
        end
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h05); send(8'h10); send(8'h00);
        checks++;
        if (imWriteEn !== 1'b1 || imAddress !== 32'h0 || imWriteData !== 32'h00100513) begin
            errors++;
            $display("FAIL %s_word0 en=%b addr=%h data=%h want 1/0/00100513",
                     tag, imWriteEn, imAddress, imWriteData);
        end
        send(8'h93); send(8'h05); send(8'h20); send(8'h00);
        byteValid = 1'b0;
        checks++;
        if (imWriteEn !== 1'b1 || imAddress !== 32'h4 || imWriteData !== 32'h00200593) begin
            errors++;
            $display("FAIL %s_word1 en=%b addr=%h data=%h want 1/4/00200593",
                     tag, imWriteEn, imAddress, imWriteData);
        end
        checks++;
        if ({byteReady, startProcess} !== 2'b00) begin
            errors++;
            $display("FAIL %s_lastwr {byteReady,start}=%b want 00", tag, {byteReady, startProcess});
        end
        tick();
        checks++;
        if ({startProcess, imWriteEn} !== 2'b10) begin
            errors++;
            $display("FAIL %s_start {start,en}=%b want 10", tag, {startProcess, imWriteEn});
        end
        tick();
        checks++;
        if ({startProcess, busy} !== 2'b01) begin
            errors++;
            $display("FAIL %s_run {start,busy}=%b want 01", tag, {startProcess, busy});
        end
        finish_run(tag);
        checks++;
        if (starts !== 1 || wa.size() !== 2) begin
            errors++;
            $display("FAIL %s_count starts=%0d writes=%0d want 1/2", tag, starts, wa.size());
        end
    endtask

    task automatic test_zero_length();
        clear_log();
        start_load();
        send(8'h00); send(8'h00);
        byteValid = 1'b0;
        checks++;
        if ({error, byteReady, busy} !== 3'b100) begin
            errors++;
            $display("FAIL zero_err {error,ready,busy}=%b want 100", {error, byteReady, busy});
        end
        tick(); tick();
        checks++;
        if (wa.size() !== 0) begin
            errors++;
            $display("FAIL zero_nowrite writes=%0d want 0", wa.size());
        end
        start_load();
        checks++;
        if ({error, byteReady, busy} !== 3'b011) begin
            errors++;
            $display("FAIL zero_reload {error,ready,busy}=%b want 011", {error, byteReady, busy});
        end
    endtask

    task automatic test_overlength();
        logic [31:0] w;
        int bad = 0;
        send(8'h01); send(8'h01);
        byteValid = 1'b0;
        checks++;
        if ({error, byteReady} !== 2'b10) begin
            errors++;
            $display("FAIL over257 {error,ready}=%b want 10", {error, byteReady});
        end
        clear_log();
        start_load();
        send(8'h00); send(8'h01);
        checks++;
        if ({error, byteReady} !== 2'b01) begin
            errors++;
            $display("FAIL over256_hdr {error,ready}=%b want 01", {error, byteReady});
        end
        for (int i = 0; i < 256; i++) begin
            w = {8'(i) ^ 8'hA5, 8'(i), 8'h3C, ~8'(i)};
            for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
        end
        byteValid = 1'b0;
        tick();
        checks++;
        if (wa.size() !== 256) begin
            errors++;
            $display("FAIL full_count writes=%0d want 256", wa.size());
        end else begin
            checks++;
            if (wa[255] !== 32'h3FC) begin
                errors++;
                $display("FAIL full_lastaddr addr=%h want 000003fc", wa[255]);
            end
            for (int i = 0; i < 256; i++) begin
                w = {8'(i) ^ 8'hA5, 8'(i), 8'h3C, ~8'(i)};
                if (wa[i] !== 32'(i * 4) || wd[i] !== w) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL full_data bad_words=%0d want 0", bad);
            end
        end
        tick();
        finish_run("full");
    endtask

    task automatic test_gaps_and_ignored();
        logic [7:0] s[10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10,
                              8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        clear_log();
        start_load();
        for (int i = 0; i < 10; i++) begin
            send(s[i]);
            byteValid = 1'b0;
            byteIn    = 8'hEE;
            if (i == 5) begin
                loadStart  = 1'b1;
                endProcess = 1'b1;
            end
            tick();
            loadStart  = 1'b0;
            endProcess = 1'b0;
            if (i == 5) begin
                checks++;
                if ({busy, byteReady, loadDone, error, startProcess} !== 5'b11000) begin
                    errors++;
                    $display("FAIL ignored_in_load flags=%b want 11000",
                             {busy, byteReady, loadDone, error, startProcess});
                end
            end
            tick();
        end
        byteValid = 1'b1;
        byteIn    = 8'hFF;
        tick(); tick(); tick();
        checks++;
        if (byteReady !== 1'b0) begin
            errors++;
            $display("FAIL gap_extra byteReady=%b want 0", byteReady);
        end
        byteValid = 1'b0;
        checks++;
        if (wa.size() !== 2 || starts !== 1) begin
            errors++;
            $display("FAIL gap_count writes=%0d starts=%0d want 2/1", wa.size(), starts);
        end else begin
            checks++;
            if (wa[0] !== 32'h0 || wd[0] !== 32'h00100513 ||
                wa[1] !== 32'h4 || wd[1] !== 32'h00200593) begin
                errors++;
                $display("FAIL gap_data w0=%h:%h w1=%h:%h want 0:00100513 4:00200593",
                         wa[0], wd[0], wa[1], wd[1]);
            end
        end
        finish_run("gap");
    endtask

    task automatic test_reset_mid_load();
        clear_log();
        start_load();
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h05); send(8'h10); send(8'h00); send(8'h93);
        byteValid = 1'b0;
        rstN = 1'b0;
        tick();
        checks++;
        if ({byteReady, imWriteEn, startProcess, busy, loadDone, error} !== 6'b0 ||
            imAddress !== 32'h0) begin
            errors++;
            $display("FAIL midreset flags=%b addr=%h want 000000/0",
                     {byteReady, imWriteEn, startProcess, busy, loadDone, error}, imAddress);
        end
        rstN = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || wa.size() !== 1) begin
            errors++;
            $display("FAIL midreset_idle busy=%b writes=%0d want 0/1", busy, wa.size());
        end
        test_normal_load("reload");
    endtask

    initial begin
        rstN       = 1'b0;
        loadStart  = 1'b0;
        byteIn     = 8'h00;
        byteValid  = 1'b0;
        endProcess = 1'b0;
        test_reset();
        test_normal_load("normal");
        test_zero_length();
        test_overlength();
        test_gaps_and_ignored();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
